// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, FSM state type and system-instruction pre-decode for the IF stage
package fetch_stage_pkg;
  localparam logic [6:0]  OPC_SYSTEM  = 7'h73;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  typedef enum logic [1:0] {FS_RUN = 2'd0, FS_HALT = 2'd1, FS_FAULT = 2'd2} fs_t;
  // Only exact ECALL/EBREAK encodings stop fetch; other SYSTEM opcodes pass through.
  function automatic logic is_halt_inst(input logic [31:0] inst);
    return inst[6:0] == OPC_SYSTEM && (inst == INST_ECALL || inst == INST_EBREAK);
  endfunction
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load (capture) and flush (bubble), async active-low reset
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  capture {fetch_pc, fetch_inst}, mark valid
//   flush                 clear valid, keep pc/inst
//   fetch_pc, fetch_inst  values to capture
//   valid, pc, inst       registered IF/ID contents
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      inst  <= INST_NOP;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= fetch_pc;
      inst  <= fetch_inst;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage - PC register, next-PC mux, ECALL/EBREAK halt, misaligned-redirect fault
//   clk, rst_n     clock, asynchronous active-low reset
//   stall          hold PC and IF/ID
//   redirect       load redirect_pc (wins over stall), flush IF/ID
//   resume         leave HALT, continue at the held PC
//   imem_addr      word address pc[IMEM_AW+1:2] (combinational)
//   imem_data      instruction at imem_addr, same cycle
//   if_id_*        IF/ID register toward decode
//   halted, fault  FSM in HALT/FAULT, FSM in FAULT
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               resume,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_inst,
  output logic               halted,
  output logic               fault
);
  fs_t         state, state_d;
  logic [31:0] pc, pc_d;
  logic        load, flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_d;
      pc    <= pc_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    load    = 1'b0;
    flush   = 1'b0;
    if (state == FS_FAULT) begin
      flush = 1'b1;
    end else if (redirect) begin
      // A redirect from HALT cancels a wrong-path halt; a misaligned target is fatal.
      flush = 1'b1;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d    = redirect_pc;
        state_d = FS_RUN;
      end else begin
        state_d = FS_FAULT;
      end
    end else if (state == FS_HALT) begin
      flush   = !stall;
      state_d = resume ? FS_RUN : FS_HALT;
    end else if (!stall) begin
      load    = 1'b1;
      pc_d    = pc + 32'd4;
      state_d = is_halt_inst(imem_data) ? FS_HALT : FS_RUN;
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .fetch_pc  (pc),
    .fetch_inst(imem_data),
    .valid     (if_id_valid),
    .pc        (if_id_pc),
    .inst      (if_id_inst)
  );

  assign imem_addr = pc[IMEM_AW+1:2];
  assign halted    = state != FS_RUN;
  assign fault     = state == FS_FAULT;
endmodule
